vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter_if.sv | 36 +++
 rtl/vram_arbiter.sv | 116 +++++++++++
 tb/tb_vram_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - display-read, game-write and RAM-port bundle for vram_arbiter
interface vram_arbiter_if #(
    parameter int AW    = 17,
    parameter int DW    = 12,
    parameter int DEPTH = 8
);
    logic                     blank;
    logic                     rd_req;
    logic [AW-1:0]            rd_addr;
    logic [DW-1:0]            rd_data;
    logic                     rd_valid;
    logic                     wr_valid;
    logic [AW-1:0]            wr_addr;
    logic [DW-1:0]            wr_data;
    logic                     wr_ready;
    logic                     ram_en;
    logic                     ram_we;
    logic [AW-1:0]            ram_addr;
    logic [DW-1:0]            ram_wdata;
    logic [DW-1:0]            ram_rdata;
    logic [$clog2(DEPTH):0]   fifo_level;
    logic                     frame_start;
    logic [15:0]              stall_cnt;

    modport slave (
        input  blank, rd_req, rd_addr, wr_valid, wr_addr, wr_data, ram_rdata,
        output rd_data, rd_valid, wr_ready, ram_en, ram_we, ram_addr, ram_wdata,
               fifo_level, frame_start, stall_cnt
    );

    modport master (
        output blank, rd_req, rd_addr, wr_valid, wr_addr, wr_data, ram_rdata,
        input  rd_data, rd_valid, wr_ready, ram_en, ram_we, ram_addr, ram_wdata,
               fifo_level, frame_start, stall_cnt
    );
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter: display reads win, buffered game writes fill the gaps
module vram_arbiter #(
    parameter int AW    = 17,
    parameter int DW    = 12,
    parameter int DEPTH = 8
) (
    input  logic          vgaclk,
    input  logic          rst_n,
    vram_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic {
        S_ACTIVE = 1'b0,
        S_VBLANK = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_fifo_addr [DEPTH];
    logic [DW-1:0] r_fifo_data [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [LW-1:0] w_level_next;
    logic          r_wr_ready;
    logic          r_rd_valid;
    logic          r_frame_start;
    logic [15:0]   r_stall_cnt;
    logic          w_push;
    logic          w_pop;
    logic          w_rd_grant;
    logic          w_empty;

    assign w_empty      = (r_level == '0);
    assign w_push       = bus.wr_valid & r_wr_ready;
    assign w_level_next = r_level + LW'(w_push) - LW'(w_pop);

    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_VBLANK;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Pops use the registered level, so a write pushed this cycle is never forwarded to the RAM.
    always_comb begin
        w_state_next = r_state;
        w_rd_grant   = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            S_ACTIVE: begin
                if (bus.blank) begin
                    w_state_next = S_VBLANK;
                end
                w_rd_grant = bus.rd_req;
                w_pop      = !bus.rd_req && !w_empty;
            end
            S_VBLANK: begin
                if (!bus.blank) begin
                    w_state_next = S_ACTIVE;
                end
                w_pop = !w_empty;
            end
            default: begin
                w_state_next = S_VBLANK;
            end
        endcase
    end

    assign bus.ram_en      = w_rd_grant | w_pop;
    assign bus.ram_we      = w_pop;
    assign bus.ram_addr    = w_rd_grant ? bus.rd_addr : r_fifo_addr[r_rd_ptr];
    assign bus.ram_wdata   = r_fifo_data[r_rd_ptr];
    assign bus.rd_data     = bus.ram_rdata;
    assign bus.rd_valid    = r_rd_valid;
    assign bus.wr_ready    = r_wr_ready;
    assign bus.fifo_level  = r_level;
    assign bus.frame_start = r_frame_start;
    assign bus.stall_cnt   = r_stall_cnt;

    always_ff @(posedge vgaclk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= bus.wr_addr;
            r_fifo_data[r_wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_wr_ready    <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_frame_start <= 1'b0;
            r_stall_cnt   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_level       <= w_level_next;
            r_wr_ready    <= (w_level_next < LW'(DEPTH));
            r_rd_valid    <= w_rd_grant;
            r_frame_start <= (r_state == S_VBLANK) && !bus.blank;
            if (bus.wr_valid && !r_wr_ready && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - randomized and directed bench for vram_arbiter against a queue-based model
module tb_vram_arbiter;
    localparam int AW    = 17;
    localparam int DW    = 12;
    localparam int DEPTH = 8;

    logic vgaclk = 1'b0;
    logic rst_n  = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    vram_arbiter_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus ();

    vram_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) u_dut (
        .vgaclk (vgaclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 vgaclk = ~vgaclk;

    // Environment RAM: 1-cycle synchronous read, untouched words return a fixed hash.
    logic [DW-1:0] tb_ram [0:511];
    bit            tb_wr  [0:511];

    function automatic logic [DW-1:0] init_val(input logic [8:0] a);
        return {a[3:0], a[8:1]} ^ 12'h5A3;
    endfunction

    always @(posedge vgaclk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) begin
                tb_ram[bus.ram_addr[8:0]] <= bus.ram_wdata;
                tb_wr[bus.ram_addr[8:0]]  <= 1'b1;
            end else begin
                bus.ram_rdata <= tb_wr[bus.ram_addr[8:0]] ? tb_ram[bus.ram_addr[8:0]]
                                                          : init_val(bus.ram_addr[8:0]);
            end
        end
    end

    // Reference model: pending writes as a queue, framebuffer contents as an array.
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           m_q[$];
    logic [DW-1:0] m_mem [0:511];
    bit            m_vblank;
    bit            m_ready;
    bit            m_rdvalid;
    bit            m_fs;
    int            m_stall;
    logic [DW-1:0] m_expdata;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_vblank  = 1'b1;
        m_ready   = 1'b0;
        m_rdvalid = 1'b0;
        m_fs      = 1'b0;
        m_stall   = 0;
    endtask

    task automatic model_edge();
        bit grant, pop, push, ready_old;
        if (!rst_n) begin
            model_reset();
            return;
        end
        grant     = !m_vblank && bus.rd_req;
        pop       = (m_q.size() > 0) && (m_vblank || !bus.rd_req);
        push      = bus.wr_valid && m_ready;
        ready_old = m_ready;
        if (grant) m_expdata = m_mem[bus.rd_addr[8:0]];
        m_rdvalid = grant;
        if (pop) begin
            m_mem[m_q[0].a[8:0]] = m_q[0].d;
            void'(m_q.pop_front());
        end
        if (push) m_q.push_back('{bus.wr_addr, bus.wr_data});
        m_ready = (m_q.size() < DEPTH);
        if (bus.wr_valid && !ready_old && m_stall != 16'hFFFF) m_stall++;
        m_fs     = m_vblank && !bus.blank;
        m_vblank = bus.blank;
    endtask

    task automatic check_all();
        bit grant, pop;
        grant = !m_vblank && bus.rd_req;
        pop   = (m_q.size() > 0) && (m_vblank || !bus.rd_req);
        check("ram_en", bus.ram_en, grant || pop);
        check("ram_we", bus.ram_we, pop);
        if (grant) check("ram_addr_rd", bus.ram_addr, bus.rd_addr);
        if (pop) begin
            check("ram_addr_wr", bus.ram_addr, m_q[0].a);
            check("ram_wdata", bus.ram_wdata, m_q[0].d);
        end
        check("fifo_level", bus.fifo_level, m_q.size());
        check("wr_ready", bus.wr_ready, m_ready);
        check("rd_valid", bus.rd_valid, m_rdvalid);
        check("frame_start", bus.frame_start, m_fs);
        check("stall_cnt", bus.stall_cnt, m_stall);
        if (m_rdvalid) check("rd_data", bus.rd_data, m_expdata);
    endtask

    task automatic step(input bit bl, input bit rq, input logic [AW-1:0] ra,
                        input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        bus.blank    = bl;
        bus.rd_req   = rq;
        bus.rd_addr  = ra;
        bus.wr_valid = wv;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        #1;
        check_all();
        @(posedge vgaclk);
        model_edge();
        #1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return ($urandom_range(3) == 0) ? 17'h100 : AW'($urandom_range(15));
    endfunction

    initial begin
        bit bl;
        for (int i = 0; i < 512; i++) m_mem[i] = init_val(9'(i));
        model_reset();
        @(posedge vgaclk);
        #1;

        // Reset hold, then release: wr_ready rises on the first edge after.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 17'h100, 1'b1, 17'h5, 12'h111);
        rst_n = 1'b1;
        step(1'b1, 1'b0, '0, 1'b0, '0, '0);
        check("ready_after_rst", bus.wr_ready, 1);

        // Three writes during blanking drain back-to-back.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b1, AW'(16 + i), DW'(12'hA00 + i));
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 17'h100, 1'b0, '0, '0);
        check("lvl_drained", bus.fifo_level, 0);

        // Active video with reads held: FIFO fills, stalls count, nothing written.
        for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 17'h100, 1'b1, AW'(32 + i), DW'(12'hB00 + i));
        check("full_ready", bus.wr_ready, 0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, '0, 1'b0, '0, '0);
        check("lvl_after_gap", bus.fifo_level, 6);
        check("ready_after_gap", bus.wr_ready, 1);
        step(1'b0, 1'b1, 17'h100, 1'b0, '0, '0);
        step(1'b0, 1'b1, 17'h10, 1'b0, '0, '0);

        // Blank pulse: drain, then frame_start with a read in the first active cycle.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 17'h100, 1'b0, '0, '0);
        step(1'b0, 1'b1, 17'h100, 1'b0, '0, '0);
        step(1'b0, 1'b1, 17'h100, 1'b0, '0, '0);
        step(1'b0, 1'b1, 17'h11, 1'b0, '0, '0);

        // Five buffered writes discarded by an asynchronous reset.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 17'h100, 1'b1, AW'(17'h1F0 + i), DW'(12'hC00 + i));
        check("lvl_before_rst", bus.fifo_level, 5);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_ram_en", bus.ram_en, 0);
        check("rst_level", bus.fifo_level, 0);
        @(posedge vgaclk);
        #1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0, '0, '0);
        for (int i = 0; i < 5; i++) check("discarded_wr", 32'(tb_wr[9'h1F0 + i]), 0);
        rst_n = 1'b1;

        // Randomized traffic with long blank/active runs.
        bl = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(15) == 0) bl = !bl;
            step(bl, 1'($urandom_range(1)), rand_addr(),
                 ($urandom_range(9) < 6), rand_addr(), DW'($urandom));
        end
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0, 1'b0, '0, '0);

        // Final framebuffer contents must match every write the model committed.
        for (int i = 0; i < 16; i++)
            check("final_mem", tb_wr[i] ? tb_ram[i] : init_val(9'(i)), m_mem[i]);
        check("final_mem_100", tb_wr[9'h100] ? tb_ram[9'h100] : init_val(9'h100), m_mem[9'h100]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
